// File: rtl/mem_port_arbiter_if.sv
// Memory-controller port bundle: command, write-data and read-data FIFO signals.
// master = arbiter side, slave = controller side.
interface mem_port_arbiter_if;
    logic        mem_cmd_en;
    logic [2:0]  mem_cmd_instr;
    logic [5:0]  mem_cmd_bl;
    logic [29:0] mem_cmd_byte_addr;
    logic        mem_cmd_full;
    logic        mem_wr_en;
    logic [3:0]  mem_wr_mask;
    logic [31:0] mem_wr_data;
    logic        mem_wr_full;
    logic        mem_wr_underrun;
    logic        mem_wr_error;
    logic        mem_rd_en;
    logic [31:0] mem_rd_data;
    logic        mem_rd_empty;
    logic        mem_rd_overflow;
    logic        mem_rd_error;

    modport master (
        output mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr,
        input  mem_cmd_full,
        output mem_wr_en, mem_wr_mask, mem_wr_data,
        input  mem_wr_full, mem_wr_underrun, mem_wr_error,
        output mem_rd_en,
        input  mem_rd_data, mem_rd_empty, mem_rd_overflow, mem_rd_error
    );

    modport slave (
        input  mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr,
        output mem_cmd_full,
        input  mem_wr_en, mem_wr_mask, mem_wr_data,
        output mem_wr_full, mem_wr_underrun, mem_wr_error,
        input  mem_rd_en,
        output mem_rd_data, mem_rd_empty, mem_rd_overflow, mem_rd_error
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter onto a single-word memory controller port.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin on ties; otherwise requester 0 has fixed priority.
module mem_port_arbiter (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                boot_done,
    input  logic                r0_req,
    input  logic                r0_we,
    input  logic [29:0]         r0_addr,
    input  logic [31:0]         r0_wdata,
    input  logic [3:0]          r0_be,
    output logic                r0_ack,
    output logic [31:0]         r0_rdata,
    input  logic                r1_req,
    input  logic                r1_we,
    input  logic [29:0]         r1_addr,
    input  logic [31:0]         r1_wdata,
    input  logic [3:0]          r1_be,
    output logic                r1_ack,
    output logic [31:0]         r1_rdata,
    mem_port_arbiter_if.master  mem,
    output logic                err
);
    typedef enum logic [2:0] {IDLE, WR_DATA, WR_CMD, RD_CMD, RD_WAIT, ACK} state_t;

    state_t      state_q, state_d;
    logic        gnt_q, gnt_d;
    logic [2:0]  instr_q, instr_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  mask_q, mask_d;
    logic        r0_ack_q, r0_ack_d, r1_ack_q, r1_ack_d;
    logic [31:0] r0_rdata_q, r0_rdata_d, r1_rdata_q, r1_rdata_d;
    logic        err_q, err_d;
    logic        cmd_en, wr_en, rd_en;
    logic        sel;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic        last_q, last_d;
`endif

    always_comb begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        sel = (r0_req && r1_req) ? !last_q : !r0_req;
`else
        sel = !r0_req;
`endif
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        instr_d    = instr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        mask_d     = mask_q;
        r0_ack_d   = 1'b0;
        r1_ack_d   = 1'b0;
        r0_rdata_d = r0_rdata_q;
        r1_rdata_d = r1_rdata_q;
        cmd_en     = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        err_d      = err_q | mem.mem_wr_underrun | mem.mem_wr_error |
                     mem.mem_rd_overflow | mem.mem_rd_error;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_d     = last_q;
`endif
        case (state_q)
            IDLE: begin
                // Stale read words are drained before any new grant.
                if (!mem.mem_rd_empty) begin
                    rd_en = 1'b1;
                end else if (boot_done && (r0_req || r1_req)) begin
                    gnt_d   = sel;
                    addr_d  = sel ? {r1_addr[29:2], 2'b00} : {r0_addr[29:2], 2'b00};
                    wdata_d = sel ? r1_wdata : r0_wdata;
                    mask_d  = sel ? ~r1_be : ~r0_be;
                    instr_d = (sel ? r1_we : r0_we) ? 3'b000 : 3'b001;
                    state_d = (sel ? r1_we : r0_we) ? WR_DATA : RD_CMD;
                end
            end
            WR_DATA: begin
                wr_en = !mem.mem_wr_full;
                if (wr_en) state_d = WR_CMD;
            end
            WR_CMD, RD_CMD: begin
                cmd_en = !mem.mem_cmd_full;
                if (cmd_en) begin
                    if (state_q == RD_CMD) begin
                        state_d = RD_WAIT;
                    end else begin
                        state_d  = ACK;
                        r0_ack_d = !gnt_q;
                        r1_ack_d = gnt_q;
                    end
                end
            end
            RD_WAIT: begin
                rd_en = !mem.mem_rd_empty;
                if (rd_en) begin
                    state_d  = ACK;
                    r0_ack_d = !gnt_q;
                    r1_ack_d = gnt_q;
                    if (gnt_q) r1_rdata_d = mem.mem_rd_data;
                    else       r0_rdata_d = mem.mem_rd_data;
                end
            end
            ACK: begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                last_d = gnt_q;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            instr_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mask_q     <= '0;
            r0_ack_q   <= 1'b0;
            r1_ack_q   <= 1'b0;
            r0_rdata_q <= '0;
            r1_rdata_q <= '0;
            err_q      <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            instr_q    <= instr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            mask_q     <= mask_d;
            r0_ack_q   <= r0_ack_d;
            r1_ack_q   <= r1_ack_d;
            r0_rdata_q <= r0_rdata_d;
            r1_rdata_q <= r1_rdata_d;
            err_q      <= err_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q     <= last_d;
`endif
        end
    end

    assign mem.mem_cmd_en        = cmd_en;
    assign mem.mem_cmd_instr     = instr_q;
    assign mem.mem_cmd_bl        = '0;
    assign mem.mem_cmd_byte_addr = addr_q;
    assign mem.mem_wr_en         = wr_en;
    assign mem.mem_wr_mask       = mask_q;
    assign mem.mem_wr_data       = wdata_q;
    assign mem.mem_rd_en         = rd_en;
    assign r0_ack                = r0_ack_q;
    assign r1_ack                = r1_ack_q;
    assign r0_rdata              = r0_rdata_q;
    assign r1_rdata              = r1_rdata_q;
    assign err                   = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; the controller side is driven by hand.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        boot_done;
    logic        r0_req, r0_we, r1_req, r1_we;
    logic [29:0] r0_addr, r1_addr;
    logic [31:0] r0_wdata, r1_wdata;
    logic [3:0]  r0_be, r1_be;
    logic        r0_ack, r1_ack;
    logic [31:0] r0_rdata, r1_rdata;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt, acks, last_cyc, n_cmd, n_ack, cmd_at;
    logic [3:0] order;
    logic [3:0] exp_order;

    mem_port_arbiter_if mem_bus ();

    mem_port_arbiter dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .boot_done(boot_done),
        .r0_req   (r0_req),
        .r0_we    (r0_we),
        .r0_addr  (r0_addr),
        .r0_wdata (r0_wdata),
        .r0_be    (r0_be),
        .r0_ack   (r0_ack),
        .r0_rdata (r0_rdata),
        .r1_req   (r1_req),
        .r1_we    (r1_we),
        .r1_addr  (r1_addr),
        .r1_wdata (r1_wdata),
        .r1_be    (r1_be),
        .r1_ack   (r1_ack),
        .r1_rdata (r1_rdata),
        .mem      (mem_bus),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        boot_done = 1'b0;
        r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0; r0_be = '0;
        r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0; r1_be = '0;
        mem_bus.mem_cmd_full    = 1'b0;
        mem_bus.mem_wr_full     = 1'b0;
        mem_bus.mem_wr_underrun = 1'b0;
        mem_bus.mem_wr_error    = 1'b0;
        mem_bus.mem_rd_data     = '0;
        mem_bus.mem_rd_empty    = 1'b1;
        mem_bus.mem_rd_overflow = 1'b0;
        mem_bus.mem_rd_error    = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_order = 4'b1010;
`else
        exp_order = 4'b0000;
`endif

        // Reset values
        repeat (2) step();
        check("rst_cmd_en",  {31'd0, mem_bus.mem_cmd_en}, 32'd0);
        check("rst_addr",    {2'd0, mem_bus.mem_cmd_byte_addr}, 32'd0);
        check("rst_wr_mask", {28'd0, mem_bus.mem_wr_mask}, 32'd0);
        check("rst_wr_data", mem_bus.mem_wr_data, 32'd0);
        check("rst_acks",    {30'd0, r0_ack, r1_ack}, 32'd0);
        check("rst_err",     {31'd0, err}, 32'd0);
        reset_n = 1'b1;

        // Boot hold: r0 requests for 20 cycles with boot_done low
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 30'h104; r0_wdata = 32'hDEADBEEF; r0_be = 4'b0011;
        cnt = 0;
        repeat (20) begin
            step();
            if (mem_bus.mem_cmd_en || mem_bus.mem_wr_en || r0_ack) cnt++;
        end
        check("boot_hold", cnt, 0);
        boot_done = 1'b1;

        // Write r0: WR_DATA, WR_CMD, ACK at cycles 1..3
        step();
        check("w_wr_en",   {31'd0, mem_bus.mem_wr_en}, 32'd1);
        check("w_wr_data", mem_bus.mem_wr_data, 32'hDEADBEEF);
        check("w_wr_mask", {28'd0, mem_bus.mem_wr_mask}, 32'hC);
        step();
        check("w_cmd_en",  {31'd0, mem_bus.mem_cmd_en}, 32'd1);
        check("w_instr",   {29'd0, mem_bus.mem_cmd_instr}, 32'd0);
        check("w_bl",      {26'd0, mem_bus.mem_cmd_bl}, 32'd0);
        check("w_addr",    {2'd0, mem_bus.mem_cmd_byte_addr}, 32'h104);
        step();
        check("w_acks",    {30'd0, r0_ack, r1_ack}, 32'b10);
        check("w_rdata0",  r0_rdata, 32'd0);
        r0_req = 1'b0;
        step();
        check("w_idle",    {30'd0, mem_bus.mem_wr_en, r0_ack}, 32'd0);

        // Read r1 of 0x10, data returns two cycles after the command
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 30'h10;
        step();
        check("r_cmd_en",  {31'd0, mem_bus.mem_cmd_en}, 32'd1);
        check("r_instr",   {29'd0, mem_bus.mem_cmd_instr}, 32'd1);
        check("r_addr",    {2'd0, mem_bus.mem_cmd_byte_addr}, 32'h10);
        step();
        check("r_wait",    {31'd0, mem_bus.mem_rd_en}, 32'd0);
        @(negedge clk);
        mem_bus.mem_rd_empty = 1'b0;
        mem_bus.mem_rd_data  = 32'h12345678;
        #1;
        check("r_rd_en",   {31'd0, mem_bus.mem_rd_en}, 32'd1);
        @(negedge clk);
        mem_bus.mem_rd_empty = 1'b1;
        r1_req = 1'b0;
        #1;
        check("r_acks",    {30'd0, r0_ack, r1_ack}, 32'b01);
        check("r_rdata1",  r1_rdata, 32'h12345678);
        check("r_rdata0",  r0_rdata, 32'd0);
        step();
        check("r_hold",    r1_rdata, 32'h12345678);

        // Both requesters held for 4 write transactions
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 30'h200; r0_wdata = 32'hA0A0A0A0; r0_be = 4'hF;
        r1_req = 1'b1; r1_we = 1'b1; r1_addr = 30'h300; r1_wdata = 32'hB1B1B1B1; r1_be = 4'hF;
        acks = 0; last_cyc = 0; order = '0;
        for (int cyc = 0; cyc < 60 && acks < 4; cyc++) begin
            step();
            if (r0_ack || r1_ack) begin
                check("arb_onehot", {31'd0, r0_ack & r1_ack}, 32'd0);
                order[acks] = r1_ack;
                if (acks > 0) check("arb_gap", cyc - last_cyc, 4);
                last_cyc = cyc;
                acks++;
                if (acks == 4) begin
                    r0_req = 1'b0;
                    r1_req = 1'b0;
                end
            end
        end
        check("arb_count", acks, 4);
        check("arb_order", {28'd0, order}, {28'd0, exp_order});
        check("arb_r1_rdata", r1_rdata, 32'h12345678);
        repeat (2) step();
        check("arb_quiet", {31'd0, mem_bus.mem_wr_en}, 32'd0);

        // Command FIFO full for 5 cycles in WR_CMD; address bits [1:0] forced low
        mem_bus.mem_cmd_full = 1'b1;
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 30'h33; r0_wdata = 32'h55AA55AA; r0_be = 4'hF;
        step();
        check("f_wr_en",   {31'd0, mem_bus.mem_wr_en}, 32'd1);
        check("f_wr_mask", {28'd0, mem_bus.mem_wr_mask}, 32'd0);
        n_cmd = 0; n_ack = 0; cmd_at = -1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i == 5) mem_bus.mem_cmd_full = 1'b0;
            #1;
            if (mem_bus.mem_cmd_en) begin
                n_cmd++;
                cmd_at = i;
                check("f_addr", {2'd0, mem_bus.mem_cmd_byte_addr}, 32'h30);
            end
            if (r0_ack) begin
                n_ack++;
                r0_req = 1'b0;
            end
        end
        check("f_cmd_count", n_cmd, 1);
        check("f_cmd_at",    cmd_at, 5);
        check("f_ack_count", n_ack, 1);

        // Reset while a read waits for data: no ack, transaction abandoned
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 30'h40;
        repeat (3) step();
        check("m_no_ack", {30'd0, r0_ack, r1_ack}, 32'd0);
        reset_n = 1'b0;
        r1_req  = 1'b0;
        #1;
        check("m_rst_rdata1", r1_rdata, 32'd0);
        check("m_rst_cmd",    {2'd0, mem_bus.mem_cmd_byte_addr}, 32'd0);

        // Late read word after reset is drained; no grant that cycle
        @(negedge clk);
        reset_n = 1'b1;
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 30'h8; r0_wdata = 32'h0000BEEF; r0_be = 4'h1;
        mem_bus.mem_rd_empty = 1'b0;
        mem_bus.mem_rd_data  = 32'h00000BAD;
        #1;
        check("d_rd_en",   {31'd0, mem_bus.mem_rd_en}, 32'd1);
        @(negedge clk);
        mem_bus.mem_rd_empty = 1'b1;
        #1;
        check("d_no_grant", {30'd0, mem_bus.mem_wr_en, mem_bus.mem_rd_en}, 32'd0);
        step();
        check("d_grant",   {31'd0, mem_bus.mem_wr_en}, 32'd1);
        check("d_mask",    {28'd0, mem_bus.mem_wr_mask}, 32'hE);
        n_ack = 0;
        for (int i = 0; i < 20 && n_ack == 0; i++) begin
            step();
            if (r0_ack) begin
                n_ack++;
                r0_req = 1'b0;
            end
        end
        check("d_ack",     n_ack, 1);
        check("d_rdata0",  r0_rdata, 32'd0);

        // Sticky error flag
        check("e_clear",   {31'd0, err}, 32'd0);
        @(negedge clk);
        mem_bus.mem_rd_overflow = 1'b1;
        @(negedge clk);
        mem_bus.mem_rd_overflow = 1'b0;
        #1;
        check("e_set",     {31'd0, err}, 32'd1);
        repeat (5) step();
        check("e_sticky",  {31'd0, err}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("e_reset",   {31'd0, err}, 32'd0);
        step();
        reset_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-word memory controller port (command, write-data and read-data FIFOs) between two requesters, e.g. the data cache and the video fetch unit. It accepts simple request/acknowledge transactions, serialises them onto the controller's `mem_*` bus and returns read data. It also drains stale read data after reset and holds off all traffic until boot completes.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `boot_done`  in  1  high once boot is complete; no grants while low.
- `rN_req`  in  1  request from requester N (N = 0, 1); held until `rN_ack`.
- `rN_we`  in  1  1 = write, 0 = read.
- `rN_addr`  in  30  byte address; bits [1:0] ignored and forced to 0.
- `rN_wdata`  in  32  write data.
- `rN_be`  in  4  byte enables; 1 = write that byte.
- `rN_ack`  out  1  one-cycle completion pulse.
- `rN_rdata`  out  32  read data, valid while `rN_ack` is high.
- `mem_cmd_en`, `mem_cmd_instr[2:0]`, `mem_cmd_bl[5:0]`, `mem_cmd_byte_addr[29:0]`  out  controller command FIFO.
- `mem_cmd_full`  in  1  command FIFO status.
- `mem_wr_en`, `mem_wr_mask[3:0]`, `mem_wr_data[31:0]`  out  write-data FIFO.
- `mem_wr_full`, `mem_wr_underrun`, `mem_wr_error`  in  1 each  write-data FIFO status.
- `mem_rd_en`  out  1  read-data FIFO pop.
- `mem_rd_data`  in  32  read-data FIFO data.
- `mem_rd_empty`, `mem_rd_overflow`, `mem_rd_error`  in  1 each  read-data FIFO status.
- `err`  out  1  sticky error flag.

## Operation
- FSM states: IDLE, WR_DATA, WR_CMD, RD_CMD, RD_WAIT, ACK.
- IDLE:
  - If `mem_rd_empty` is low, assert `mem_rd_en` and discard the word. No grant is issued that cycle (stale-data drain).
  - Otherwise, if `boot_done` is high and any `rN_req` is high, grant one requester. Latch its `we`, `addr` (with [1:0] = 0), `wdata` and `be`.
  - Next state is WR_DATA if `we` = 1, else RD_CMD.
- WR_DATA: `mem_wr_en` = !`mem_wr_full`. `mem_wr_data` = latched `wdata`; `mem_wr_mask` = ~`be`. Advance to WR_CMD when the push occurs.
- WR_CMD: `mem_cmd_en` = !`mem_cmd_full` with `instr` = 3'b000 and `bl` = 0. Advance to ACK on push.
- RD_CMD: same as WR_CMD but `instr` = 3'b001. Advance to RD_WAIT on push.
- RD_WAIT: `mem_rd_en` = !`mem_rd_empty`. On pop, latch `mem_rd_data` into the granted requester's `rdata` and advance to ACK.
- ACK: pulse `ack` to the granted requester only, record it as last-granted, return to IDLE.
- Dropping `rN_req` before `ack` does not abort the transaction; `ack` still pulses.
- `rN_rdata` holds its value until the next read completes for that requester. After a write it is unchanged.
- `err` is set on any of `mem_wr_underrun`, `mem_wr_error`, `mem_rd_overflow` or `mem_rd_error`, and is cleared only by reset.
- FIFO enables are combinational decodes of state and FIFO flags. Every other output is registered.

## Timing
- Reset values: state IDLE; every `mem_*` output 0; `rN_ack` 0; `rN_rdata` 0; `err` 0; last-granted = 1, so requester 0 wins the first tie.
- Reset mid-transaction abandons it immediately with no ack. Any read word the controller returns later is drained in IDLE.
- Write, no stalls: grant at cycle 0; `mem_wr_en` at cycle 1; `mem_cmd_en` at cycle 2; `ack` at cycle 3; IDLE at cycle 4.
- Read, no stalls: grant at cycle 0; `mem_cmd_en` at cycle 1; `mem_rd_en` at cycle 2 at the earliest; `ack` the cycle after `mem_rd_en`.
- A full or empty FIFO stalls the FSM in its current state indefinitely, with no timeout.
- Back-to-back grants are separated by at least one IDLE cycle.
- `boot_done` falling mid-transaction does not abort it; only new grants are blocked.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: when both requests are high in IDLE, grant the requester that was not last-granted.
- Undefined: fixed priority, requester 0 always wins, and the last-granted register is not implemented.

## Test plan
- Hold `boot_done` = 0 and raise `r0_req` for 20 cycles → no `mem_cmd_en`, no ack. Raise `boot_done` → grant occurs the next cycle.
- r0 write to address 0x00000104, data 0xDEADBEEF, `be` 4'b0011 → `mem_wr_data` = 0xDEADBEEF, `mem_wr_mask` = 4'b1100, `instr` = 0, `bl` = 0, `addr` = 0x104; `r0_ack` at cycle 3.
- r1 read of address 0x10, FIFO returns 0x12345678 two cycles after the command → `r1_rdata` = 0x12345678 with `r1_ack`; `r0_ack` stays 0.
- Both requesters held continuously for 4 transactions → with the macro, grant order 0,1,0,1; without it, 0,0,0,0.
- `mem_cmd_full` high for 5 cycles in WR_CMD, then `mem_rd_empty` low while IDLE after reset → exactly one `mem_cmd_en` once the FIFO frees; the stale word is popped and no grant is issued that cycle.
- Pulse `mem_rd_overflow` for 1 cycle → `err` = 1 and stays 1 until `reset_n` is asserted low.
